// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package dmem_pkg;

  localparam int WORD_W        = 32;
  localparam int DEFAULT_DEPTH = 8;
  localparam int MAX_AW        = 10;

  typedef enum logic {
    PORT_PIPE = 1'b0,
    PORT_DBG  = 1'b1
  } port_sel_e;

  typedef struct packed {
    logic [MAX_AW-1:0] idx;
    logic              err;
  } addr_chk_t;

  // Word index plus a combined misaligned/out-of-range flag for a byte address.
  function automatic addr_chk_t check_addr(input logic [31:0] addr, input int aw);
    addr_chk_t r;
    r.idx = addr[MAX_AW+1:2] & ~({MAX_AW{1'b1}} << aw);
    r.err = (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the port not served last wins a conflict.
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_sel_e last_gnt_q;
  port_sel_e last_gnt_d;

  // Grant selection and last-winner bookkeeping; nothing is granted during reset.
  always_comb begin
    gnt        = 2'b00;
    last_gnt_d = last_gnt_q;
    if (!reset) begin
      if (req[0] && (!req[1] || (last_gnt_q == PORT_DBG))) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
    if (gnt[0]) begin
      last_gnt_d = PORT_PIPE;
    end else if (gnt[1]) begin
      last_gnt_d = PORT_DBG;
    end
  end

  // Last-winner register; reset favours the pipeline on the first conflict.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt_q <= PORT_DBG;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory shared by the pipeline MEM stage and the debug port.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [WORD_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [WORD_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [WORD_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [WORD_W-1:0] p1_rdata,
  output logic              p1_err
);

  logic [1:0]              gnt;
  logic                    acc_we;
  logic [31:0]             acc_addr;
  logic [WORD_W-1:0]       acc_wdata;
  addr_chk_t               chk;
  logic [AW-1:0]           acc_idx;
  logic                    wr_en;
  logic [WORD_W-1:0]       rd_word;
  logic                    unused_idx_hi;

  logic [WORD_W-1:0]       mem_q [DEPTH];
  logic [WORD_W-1:0]       mem_d [DEPTH];
  logic [1:0]              rvalid_q, rvalid_d;
  logic [1:0]              err_q, err_d;
  logic [1:0][WORD_W-1:0]  rdata_q, rdata_d;

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   ({p1_req, p0_req}),
    .gnt   (gnt)
  );

  // Route the winning port's request onto the single memory access path.
  always_comb begin
    acc_we    = p0_we;
    acc_addr  = p0_addr;
    acc_wdata = p0_wdata;
    if (gnt[1]) begin
      acc_we    = p1_we;
      acc_addr  = p1_addr;
      acc_wdata = p1_wdata;
    end
  end

  assign chk           = check_addr(acc_addr, AW);
  assign acc_idx       = chk.idx[AW-1:0];
  assign unused_idx_hi = ^(chk.idx >> AW);
  assign wr_en         = (|gnt) && acc_we && !chk.err;
  assign rd_word       = mem_q[acc_idx];

  // Next memory contents: only a granted, legal store changes a word.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[acc_idx] = acc_wdata;
    end
  end

  // Per-port responses: rvalid/err pulse, rdata holds until the next granted load.
  always_comb begin
    rvalid_d = 2'b00;
    err_d    = 2'b00;
    rdata_d  = rdata_q;
    for (int p = 0; p < 2; p++) begin
      if (gnt[p]) begin
        rvalid_d[p] = !acc_we;
        err_d[p]    = chk.err;
        if (!acc_we) begin
          rdata_d[p] = chk.err ? '0 : rd_word;
        end
      end
    end
  end

  // Memory array and response registers, all cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rdata_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid_q[0] && !reset;
  assign p1_rvalid = rvalid_q[1] && !reset;
  assign p0_err    = err_q[0] && !reset;
  assign p1_err    = err_q[1] && !reset;
  assign p0_rdata  = rdata_q[0];
  assign p1_rdata  = rdata_q[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for the shared data-memory arbiter.
module tb_dmem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic        p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic        p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_rdata;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  dmem_port_arbiter #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_p0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
  endtask

  task automatic drive_p1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_p0(1'b1, 1'b0, 32'h0, 32'h0);
    drive_p1(1'b1, 1'b0, 32'h4, 32'h0);
    #1;
    total++; if ({p0_gnt, p1_gnt} !== 2'b00) $display("[TB] FAIL reset_gnt: got %b expected 00", {p0_gnt, p1_gnt}); else passed++;
    step();
    step();
    reset = 1'b0;
    drive_p0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_p1(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    total++; if ({p0_rvalid, p1_rvalid} !== 2'b00) $display("[TB] FAIL reset_rvalid: got %b expected 00", {p0_rvalid, p1_rvalid}); else passed++;
    total++; if ({p0_err, p1_err} !== 2'b00) $display("[TB] FAIL reset_err: got %b expected 00", {p0_err, p1_err}); else passed++;
    total++; if (p0_rdata !== 32'h0) $display("[TB] FAIL reset_p0_rdata: got %h expected 0", p0_rdata); else passed++;
    total++; if (p1_rdata !== 32'h0) $display("[TB] FAIL reset_p1_rdata: got %h expected 0", p1_rdata); else passed++;
  endtask

  task automatic test_preload();
    for (int i = 0; i < 8; i++) begin
      drive_p1(1'b1, 1'b1, 32'(i * 4), 32'h11111111 * 32'(i + 1));
      #1;
      total++; if (p1_gnt !== 1'b1) $display("[TB] FAIL preload_gnt%0d: got %b expected 1", i, p1_gnt); else passed++;
      step();
      total++; if ({p1_rvalid, p1_err} !== 2'b00) $display("[TB] FAIL preload_resp%0d: got %b expected 00", i, {p1_rvalid, p1_err}); else passed++;
    end
    drive_p1(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_round_robin();
    logic [31:0] p0a [4] = '{32'h00, 32'h08, 32'h08, 32'h10};
    logic [31:0] p1a [4] = '{32'h04, 32'h04, 32'h0C, 32'h0C};
    logic        g0  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] rd  [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int c = 0; c < 4; c++) begin
      drive_p0(1'b1, 1'b0, p0a[c], 32'h0);
      drive_p1(1'b1, 1'b0, p1a[c], 32'h0);
      #1;
      total++; if ({p0_gnt, p1_gnt} !== {g0[c], !g0[c]}) $display("[TB] FAIL rr_gnt%0d: got %b expected %b", c, {p0_gnt, p1_gnt}, {g0[c], !g0[c]}); else passed++;
      step();
      total++; if ({p0_rvalid, p1_rvalid} !== {g0[c], !g0[c]}) $display("[TB] FAIL rr_rvalid%0d: got %b expected %b", c, {p0_rvalid, p1_rvalid}, {g0[c], !g0[c]}); else passed++;
      total++; if ((g0[c] ? p0_rdata : p1_rdata) !== rd[c]) $display("[TB] FAIL rr_rdata%0d: got %h expected %h", c, (g0[c] ? p0_rdata : p1_rdata), rd[c]); else passed++;
    end
    drive_p0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_p1(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_read_back();
    drive_p0(1'b1, 1'b0, 32'h1C, 32'h0);
    #1;
    total++; if (p0_gnt !== 1'b1) $display("[TB] FAIL readback_gnt: got %b expected 1", p0_gnt); else passed++;
    step();
    drive_p0(1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (p0_rvalid !== 1'b1) $display("[TB] FAIL readback_rvalid: got %b expected 1", p0_rvalid); else passed++;
    total++; if (p0_rdata !== 32'h88888888) $display("[TB] FAIL readback_rdata: got %h expected 88888888", p0_rdata); else passed++;
    step();
    total++; if (p0_rvalid !== 1'b0) $display("[TB] FAIL readback_pulse: got %b expected 0", p0_rvalid); else passed++;
    total++; if (p0_rdata !== 32'h88888888) $display("[TB] FAIL readback_hold: got %h expected 88888888", p0_rdata); else passed++;
  endtask

  task automatic test_store_load();
    drive_p0(1'b1, 1'b1, 32'h08, 32'hDEADBEEF);
    #1;
    total++; if (p0_gnt !== 1'b1) $display("[TB] FAIL st_gnt: got %b expected 1", p0_gnt); else passed++;
    step();
    drive_p0(1'b1, 1'b0, 32'h08, 32'h0);
    total++; if ({p0_rvalid, p0_err} !== 2'b00) $display("[TB] FAIL st_resp: got %b expected 00", {p0_rvalid, p0_err}); else passed++;
    step();
    drive_p0(1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (p0_rvalid !== 1'b1) $display("[TB] FAIL stld_rvalid: got %b expected 1", p0_rvalid); else passed++;
    total++; if (p0_rdata !== 32'hDEADBEEF) $display("[TB] FAIL stld_rdata: got %h expected deadbeef", p0_rdata); else passed++;
    step();
  endtask

  task automatic test_errors();
    drive_p0(1'b1, 1'b0, 32'h06, 32'h0);
    step();
    drive_p0(1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
    total++; if ({p0_err, p0_rvalid} !== 2'b11) $display("[TB] FAIL misalign_resp: got %b expected 11", {p0_err, p0_rvalid}); else passed++;
    total++; if (p0_rdata !== 32'h0) $display("[TB] FAIL misalign_rdata: got %h expected 0", p0_rdata); else passed++;
    step();
    drive_p0(1'b1, 1'b0, 32'h00, 32'h0);
    total++; if ({p0_err, p0_rvalid} !== 2'b10) $display("[TB] FAIL range_resp: got %b expected 10", {p0_err, p0_rvalid}); else passed++;
    step();
    drive_p0(1'b0, 1'b0, 32'h0, 32'h0);
    total++; if ({p0_err, p0_rvalid} !== 2'b01) $display("[TB] FAIL after_err_resp: got %b expected 01", {p0_err, p0_rvalid}); else passed++;
    total++; if (p0_rdata !== 32'h11111111) $display("[TB] FAIL after_err_rdata: got %h expected 11111111", p0_rdata); else passed++;
    step();
    total++; if ({p0_err, p0_rvalid} !== 2'b00) $display("[TB] FAIL err_pulse: got %b expected 00", {p0_err, p0_rvalid}); else passed++;
  endtask

  task automatic test_reset_inflight();
    drive_p0(1'b1, 1'b0, 32'h04, 32'h0);
    #1;
    total++; if (p0_gnt !== 1'b1) $display("[TB] FAIL inflight_gnt: got %b expected 1", p0_gnt); else passed++;
    step();
    drive_p0(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    total++; if (p0_rvalid !== 1'b0) $display("[TB] FAIL inflight_rvalid_n1: got %b expected 0", p0_rvalid); else passed++;
    step();
    reset = 1'b0;
    #1;
    total++; if (p0_rvalid !== 1'b0) $display("[TB] FAIL inflight_rvalid_n2: got %b expected 0", p0_rvalid); else passed++;
    for (int i = 0; i < 8; i++) begin
      drive_p1(1'b1, 1'b0, 32'(i * 4), 32'h0);
      step();
      total++; if ({p1_rvalid, p1_rdata} !== {1'b1, 32'h0}) $display("[TB] FAIL cleared_word%0d: got %b/%h expected 1/00000000", i, p1_rvalid, p1_rdata); else passed++;
    end
    drive_p0(1'b1, 1'b0, 32'h0, 32'h0);
    drive_p1(1'b1, 1'b0, 32'h4, 32'h0);
    #1;
    total++; if ({p0_gnt, p1_gnt} !== 2'b10) $display("[TB] FAIL post_reset_conflict: got %b expected 10", {p0_gnt, p1_gnt}); else passed++;
    step();
    drive_p0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_p1(1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_p1_hold();
    drive_p1(1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({p0_gnt, p1_gnt} !== 2'b01) $display("[TB] FAIL p1_alone%0d: got %b expected 01", i, {p0_gnt, p1_gnt}); else passed++;
      step();
    end
    drive_p0(1'b1, 1'b0, 32'h4, 32'h0);
    #1;
    total++; if ({p0_gnt, p1_gnt} !== 2'b10) $display("[TB] FAIL p0_joins: got %b expected 10", {p0_gnt, p1_gnt}); else passed++;
    step();
    drive_p0(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    total++; if ({p0_gnt, p1_gnt} !== 2'b01) $display("[TB] FAIL p1_resumes: got %b expected 01", {p0_gnt, p1_gnt}); else passed++;
    step();
    drive_p1(1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  initial begin
    $display("[TB] starting dmem_port_arbiter bench");
    test_reset();
    test_preload();
    test_round_robin();
    test_read_back();
    test_store_load();
    test_errors();
    test_reset_inflight();
    test_p1_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
